ls_queue: RTL and testbench
===========================

# ls_queue

Load/store queue between the MEM stage and the L1 data cache. Accepts load/store requests over a valid/rdy handshake, buffers up to DEPTH of them in order, and issues them one at a time to the L1 D$ request/ack port. Load results return byte-lane-extracted and sign/zero-extended toward WB; store completions return as single-cycle pulses. Strictly in-order, one outstanding D$ request.

## Interface
- DEPTH, 4: queue entries, power of 2, ≥2
- AW, 32: address width (PC_SZ)
- DW, 32: data width (RSZ)
- TW, 5: load destination tag width (GPR_ASZ)

Ports:
- clk_in  in  1  clock
- reset_in  in  1  asynchronous, active-low reset
- flush_in  in  1  discard queued, unissued entries
- lsq_valid  in  1  MEM offers entry
- lsq_rdy  out  1  queue can accept; = !full && !flush_in
- lsq_rd  in  1  1 = load, 0 = store
- lsq_addr  in  AW  byte address
- lsq_wr_data  in  DW  store data, already lane-aligned
- lsq_size  in  3  byte count: 1, 2 or 4
- lsq_zero_ext  in  1  1 = zero-extend load, 0 = sign-extend
- lsq_tag  in  TW  load Rd address
- dc_req  out  1  D$ request, held until ack
- dc_addr  out  AW  head address, word-aligned (addr[1:0] forced 0)
- dc_rd / dc_wr  out  1 each  head is load / store
- dc_wr_data  out  DW  head store data
- dc_size  out  3  head size
- dc_ack  in  1  D$ completes head request
- dc_ack_data  in  DW  aligned read word
- dc_ack_fault  in  1  access fault, valid with dc_ack
- ld_valid  out  1  one-cycle load result
- ld_tag  out  TW  result Rd address
- ld_data  out  DW  extended load data
- st_done  out  1  one-cycle store completion
- fault  out  1  one-cycle, with ld_valid/st_done, access faulted
- count  out  $clog2(DEPTH)+1  occupancy
- halted  out  1  see Configuration

## Operation
- Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits plus wrap bit; full = pointers equal with differing wrap bits; empty = equal with equal wrap bits.
- Push on lsq_valid && lsq_rdy. lsq_rdy derives from registered count; no same-cycle bypass of a pop, so a full queue refuses even while popping.
- FSM: IDLE, REQ, (HALT if configured).
  - IDLE → REQ when !empty && !flush_in.
  - REQ: dc_req=1, dc_* driven from head entry, held stable. REQ → IDLE on dc_ack; head popped at the same edge.
- On ack: load → ld_valid, ld_tag, ld_data; store → st_done; fault = dc_ack_fault.
- Load extraction: lane = addr[1:0]. size 1 → byte at dc_ack_data[8*lane+:8]. Size 2 → half at lane[1]*16. Size 4 → full word. Bit 7/15 extended unless zero_ext. Faulted loads return ld_data=0.
- flush_in: all entries not currently in REQ are discarded (wr_ptr := rd_ptr, or rd_ptr+1 if in REQ). An outstanding request completes and reports normally. Push is blocked during flush.

## Timing
- Reset: all outputs 0; count=0; pointers 0; state IDLE.
- Accept at edge E0 → dc_req high from E1 (minimum 1-cycle latency from an empty queue).
- dc_ack sampled at edge Ea → ld_valid/st_done high for cycle Ea..Ea+1 only. Next dc_req earliest from Ea+1, because IDLE always lasts ≥1 cycle.
- Back-to-back throughput: one access per 2 cycles plus D$ latency.
- count updates at the push/pop edge; push and pop at the same edge leave count unchanged.
- Async reset mid-request drops dc_req immediately. The D$ must tolerate a withdrawn request.

## Configuration
- LSQ_FAULT_HALT_EN defined: a faulted ack moves the FSM to HALT. Fault is reported once. halted=1, dc_req=0, and the queue keeps accepting until full. flush_in clears the queue and returns the FSM to IDLE at the next edge.
- Undefined: faults are reported, draining continues, and halted is tied to 0.

## Test plan
- Reset: drive reset_in=0 mid-REQ → all outputs 0 asynchronously; count=0 after release.
- Load byte: addr 0x103, size 1, zero_ext 0, ack_data 0x80FF_FF12 → ld_data 0xFFFF_FF80, ld_valid one cycle after ack.
- Fill: push 4 stores with dc_ack held 0 → count=4 and lsq_rdy=0. Ack each after 3 cycles → 4 st_done pulses in order and lsq_rdy=1 after the first pop.
- Flush: 3 entries queued, head in REQ, flush_in for 1 cycle → count=1. Head ack yields exactly one completion; no further dc_req.
- Fault (LSQ_FAULT_HALT_EN): load acked with dc_ack_fault=1 → fault=1, ld_data=0, halted=1, no dc_req until flush_in.
- Half-word zero-extend: addr 0x202, size 2, ack_data 0xBEEF_1234 → ld_data 0x0000_BEEF.

Source files
------------

// File: rtl/ls_queue_if.sv
// ls_queue_if: MEM-side request, L1 D$ request/ack and WB-side result bundle for ls_queue.
interface ls_queue_if #(parameter int AW = 32, DW = 32, TW = 5);
    logic          lsq_valid, lsq_rdy, lsq_rd, lsq_zero_ext;
    logic [AW-1:0] lsq_addr;
    logic [DW-1:0] lsq_wr_data;
    logic [2:0]    lsq_size;
    logic [TW-1:0] lsq_tag;
    logic          dc_req, dc_rd, dc_wr, dc_ack, dc_ack_fault;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wr_data, dc_ack_data;
    logic [2:0]    dc_size;
    logic          ld_valid, st_done, fault;
    logic [TW-1:0] ld_tag;
    logic [DW-1:0] ld_data;
    modport master (
        output lsq_valid, lsq_rd, lsq_addr, lsq_wr_data, lsq_size, lsq_zero_ext, lsq_tag,
        input  lsq_rdy,
        input  dc_req, dc_addr, dc_rd, dc_wr, dc_wr_data, dc_size,
        output dc_ack, dc_ack_data, dc_ack_fault,
        input  ld_valid, ld_tag, ld_data, st_done, fault
    );
    modport slave (
        input  lsq_valid, lsq_rd, lsq_addr, lsq_wr_data, lsq_size, lsq_zero_ext, lsq_tag,
        output lsq_rdy,
        output dc_req, dc_addr, dc_rd, dc_wr, dc_wr_data, dc_size,
        input  dc_ack, dc_ack_data, dc_ack_fault,
        output ld_valid, ld_tag, ld_data, st_done, fault
    );
endinterface

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue feeding the L1 D$, one outstanding request.
// Define LSQ_FAULT_HALT_EN to halt issue after a faulted access until flush_in.
module ls_queue #(parameter int DEPTH = 4, AW = 32, DW = 32, TW = 5) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   flush_in,
    ls_queue_if.slave              bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   halted
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1;
`ifdef LSQ_FAULT_HALT_EN
    localparam logic [1:0] HALT = 2'd2;
`endif
    logic [1:0]    state, nxt;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [2:0]    size_q [DEPTH];
    logic [TW-1:0] tag_q  [DEPTH];
    logic          rd_q   [DEPTH];
    logic          zx_q   [DEPTH];
    logic [PW-1:0] head;
    logic          push, pop, empty, full;
    logic [1:0]    lane;
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] ext;
    assign head  = rd_ptr[PW-1:0];
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = count == (PW+1)'(DEPTH);
    assign bus.lsq_rdy = reset_in && !full && !flush_in;
    assign push  = bus.lsq_valid && bus.lsq_rdy;
    assign pop   = state == REQ && bus.dc_ack;
    // Request fields are gated by dc_req so the bus idles at zero
    assign bus.dc_req     = state == REQ;
    assign bus.dc_addr    = bus.dc_req ? {addr_q[head][AW-1:2], 2'b00} : '0;
    assign bus.dc_rd      = bus.dc_req && rd_q[head];
    assign bus.dc_wr      = bus.dc_req && !rd_q[head];
    assign bus.dc_wr_data = bus.dc_req ? data_q[head] : '0;
    assign bus.dc_size    = bus.dc_req ? size_q[head] : '0;
    always_comb begin
        lane = addr_q[head][1:0];
        b    = bus.dc_ack_data[{lane, 3'b000} +: 8];
        h    = lane[1] ? bus.dc_ack_data[31:16] : bus.dc_ack_data[15:0];
        ext  = size_q[head] == 3'd1 ? {{(DW-8){!zx_q[head] && b[7]}}, b} :
               size_q[head] == 3'd2 ? {{(DW-16){!zx_q[head] && h[15]}}, h} : bus.dc_ack_data;
    end
    always_comb begin
        nxt = state;
        if (state == IDLE && !empty && !flush_in) nxt = REQ;
        if (pop) nxt = IDLE;
`ifdef LSQ_FAULT_HALT_EN
        if (pop && bus.dc_ack_fault) nxt = HALT;
        if (state == HALT && flush_in) nxt = IDLE;
`endif
    end
`ifdef LSQ_FAULT_HALT_EN
    assign halted = state == HALT;
`else
    assign halted = 1'b0;
`endif
    always_ff @(posedge clk_in)
        if (push) begin
            addr_q[wr_ptr[PW-1:0]] <= bus.lsq_addr;
            data_q[wr_ptr[PW-1:0]] <= bus.lsq_wr_data;
            size_q[wr_ptr[PW-1:0]] <= bus.lsq_size;
            tag_q[wr_ptr[PW-1:0]]  <= bus.lsq_tag;
            rd_q[wr_ptr[PW-1:0]]   <= bus.lsq_rd;
            zx_q[wr_ptr[PW-1:0]]   <= bus.lsq_zero_ext;
        end
    always_ff @(posedge clk_in or negedge reset_in)
        if (!reset_in) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.ld_valid <= 1'b0;
            bus.st_done  <= 1'b0;
            bus.fault    <= 1'b0;
            bus.ld_tag   <= '0;
            bus.ld_data  <= '0;
        end else begin
            state        <= nxt;
            bus.ld_valid <= pop && rd_q[head];
            bus.st_done  <= pop && !rd_q[head];
            bus.fault    <= pop && bus.dc_ack_fault;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // The in-flight head survives a flush; everything behind it is dropped
            if (flush_in) wr_ptr <= rd_ptr + (PW+1)'(state == REQ);
            if (pop && rd_q[head]) begin
                bus.ld_tag  <= tag_q[head];
                bus.ld_data <= bus.dc_ack_fault ? '0 : ext;
            end
        end
endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: scoreboard bench for ls_queue with an in-order D$ responder model.
module tb_ls_queue;
    logic clk_in = 0, reset_in = 0, flush_in = 0;
    logic [2:0] count;
    logic halted;
    ls_queue_if #(.AW(32), .DW(32), .TW(5)) bus();
    ls_queue #(.DEPTH(4), .AW(32), .DW(32), .TW(5)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in),
        .bus(bus.slave), .count(count), .halted(halted));
    always #5 clk_in = ~clk_in;

    typedef struct {bit rd; logic [4:0] tag; logic [31:0] data; bit flt;} exp_t;
    typedef struct {logic [31:0] addr, word, wd; bit flt, rd; logic [2:0] sz;} rsp_t;
    exp_t sb[$];
    rsp_t rq[$];
    int n_tests = 0, n_fail = 0, n_done = 0;
    int lat = 0;
    bit ack_en = 0;
    int wait_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ext_ref(input logic [31:0] w, input logic [1:0] ln,
                                            input logic [2:0] sz, input bit zx);
        logic [31:0] s;
        if (sz == 1) begin
            s = w >> (8 * ln);
            return zx ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        end
        if (sz == 2) begin
            s = ln[1] ? w >> 16 : w;
            return zx ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        end
        return w;
    endfunction

    // D$ model: acks the head request lat cycles after it appears
    always @(negedge clk_in) begin
        rsp_t r;
        bus.dc_ack = 0;
        bus.dc_ack_fault = 0;
        bus.dc_ack_data = 32'h0;
        if (bus.dc_req && ack_en) begin
            if (wait_cnt >= lat) begin
                wait_cnt = 0;
                if (rq.size() == 0) check("unexp_req", 1, 0);
                else begin
                    r = rq.pop_front();
                    check("dc_addr", bus.dc_addr, r.addr);
                    check("dc_rd", {bus.dc_rd, bus.dc_wr}, {r.rd, !r.rd});
                    check("dc_size", bus.dc_size, r.sz);
                    if (!r.rd) check("dc_wr_data", bus.dc_wr_data, r.wd);
                    bus.dc_ack = 1;
                    bus.dc_ack_data = r.word;
                    bus.dc_ack_fault = r.flt;
                end
            end else wait_cnt++;
        end else wait_cnt = 0;
    end

    always @(negedge clk_in) begin
        exp_t e;
        if (reset_in && (bus.ld_valid || bus.st_done)) begin
            n_done++;
            if (sb.size() == 0) check("unexp_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("kind", {bus.ld_valid, bus.st_done}, {e.rd, !e.rd});
                check("fault", bus.fault, e.flt);
                if (e.rd) begin
                    check("ld_tag", bus.ld_tag, e.tag);
                    check("ld_data", bus.ld_data, e.data);
                end
            end
        end
    end

    task automatic send(input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, input bit zx, input logic [4:0] tg,
                        input logic [31:0] word, input bit flt, input logic [31:0] ed,
                        input bit exp);
        int n = 0;
        if (exp) begin
            sb.push_back('{rd: rd, tag: tg, data: ed, flt: flt});
            rq.push_back('{addr: {a[31:2], 2'b00}, word: word, wd: d, flt: flt, rd: rd, sz: sz});
        end
        bus.lsq_valid = 1; bus.lsq_rd = rd; bus.lsq_addr = a; bus.lsq_wr_data = d;
        bus.lsq_size = sz; bus.lsq_zero_ext = zx; bus.lsq_tag = tg;
        while (!bus.lsq_rdy && n < 200) begin @(negedge clk_in); n++; end
        if (n >= 200) check("rdy_timeout", 0, 1);
        else @(negedge clk_in);
        bus.lsq_valid = 0;
    endtask

    task automatic wait_done(input int target);
        int c = 0;
        while (n_done < target && c < 500) begin @(negedge clk_in); c++; end
        check("done_timeout", n_done >= target, 1);
    endtask

    task automatic count_reqs(input int cycles, output int reqs);
        reqs = 0;
        for (int i = 0; i < cycles; i++) begin @(negedge clk_in); reqs += int'(bus.dc_req); end
    endtask

    initial begin
        int reqs, base;
        bit rd, zx, flt;
        logic [31:0] a, w, d;
        logic [2:0] sz;
        bus.lsq_valid = 0; bus.lsq_rd = 0; bus.lsq_addr = 0; bus.lsq_wr_data = 0;
        bus.lsq_size = 0; bus.lsq_zero_ext = 0; bus.lsq_tag = 0;
        bus.dc_ack = 0; bus.dc_ack_data = 0; bus.dc_ack_fault = 0;
        #12;
        check("rst_count", count, 0);
        check("rst_outs", {bus.dc_req, bus.ld_valid, bus.st_done, bus.fault, bus.lsq_rdy, halted}, 0);
        @(negedge clk_in) reset_in = 1;
        @(negedge clk_in);
        check("rdy_after_rst", bus.lsq_rdy, 1);

        // Sign-extended byte load, plus request latency from an empty queue
        send(1, 32'h103, 0, 1, 0, 5'd7, 32'h80FF_FF12, 0, 32'hFFFF_FF80, 1);
        check("req_lat_e0", bus.dc_req, 0);
        @(negedge clk_in);
        check("req_lat_e1", bus.dc_req, 1);
        ack_en = 1; lat = 0;
        wait_done(1);
        @(negedge clk_in);
        check("ld_pulse_1cyc", bus.ld_valid, 0);

        send(1, 32'h202, 0, 2, 1, 5'd3, 32'hBEEF_1234, 0, 32'h0000_BEEF, 1);
        wait_done(2);

        // Fill with acks withheld, then drain with 3-cycle D$ latency
        ack_en = 0;
        for (int i = 0; i < 4; i++)
            send(0, 32'h400 + 4 * i, 32'hA000_0000 + i, 4, 0, 0, 0, 0, 0, 1);
        check("fill_count", count, 4);
        check("fill_rdy", bus.lsq_rdy, 0);
        base = n_done;
        lat = 3; ack_en = 1;
        wait_done(base + 1);
        check("rdy_after_pop", bus.lsq_rdy, 1);
        check("count_after_pop", count, 3);
        wait_done(base + 4);
        check("drain_count", count, 0);

        // Flush with head in REQ: only the head completes
        ack_en = 0;
        send(0, 32'h500, 32'h1111, 4, 0, 0, 0, 0, 0, 1);
        send(1, 32'h504, 0, 4, 0, 5'd9, 0, 0, 0, 0);
        send(0, 32'h508, 32'h2222, 4, 0, 0, 0, 0, 0, 0);
        check("flush_pre_count", count, 3);
        check("flush_pre_req", bus.dc_req, 1);
        flush_in = 1;
        #1 check("flush_rdy", bus.lsq_rdy, 0);
        @(negedge clk_in) flush_in = 0;
        check("flush_count", count, 1);
        base = n_done;
        lat = 1; ack_en = 1;
        wait_done(base + 1);
        count_reqs(10, reqs);
        check("flush_no_req", reqs, 0);
        check("flush_extra_done", n_done, base + 1);

        // Random mixed traffic against the extraction model
        for (int i = 0; i < 24; i++) begin
            rd = 1'($urandom); zx = 1'($urandom);
            a = $urandom; w = $urandom; d = $urandom;
            sz = 3'(1 << $urandom_range(0, 2));
`ifdef LSQ_FAULT_HALT_EN
            flt = 0;
`else
            flt = ($urandom_range(0, 7) == 0);
`endif
            lat = $urandom_range(0, 2);
            send(rd, a, d, sz, zx, 5'($urandom), w, flt, flt ? 32'h0 : ext_ref(w, a[1:0], sz, zx), 1);
        end
        wait_done(n_done + sb.size());
        check("rand_drained", sb.size(), 0);

        // Faulted load
        base = n_done;
        lat = 0;
        send(1, 32'h601, 0, 1, 1, 5'd12, 32'h0000_5500, 1, 32'h0, 1);
        wait_done(base + 1);
`ifdef LSQ_FAULT_HALT_EN
        check("halted", halted, 1);
        send(0, 32'h700, 32'h3333, 4, 0, 0, 0, 0, 0, 0);
        count_reqs(6, reqs);
        check("halt_no_req", reqs, 0);
        check("halt_count", count, 1);
        flush_in = 1;
        @(negedge clk_in) flush_in = 0;
        check("halt_cleared", {halted, count}, 0);
`else
        check("no_halt", halted, 0);
        send(0, 32'h700, 32'h3333, 4, 0, 0, 0, 0, 0, 1);
        wait_done(base + 2);
`endif

        // Asynchronous reset mid-request
        ack_en = 0;
        send(1, 32'h800, 0, 4, 0, 5'd1, 0, 0, 0, 1);
        @(negedge clk_in);
        check("pre_rst_req", bus.dc_req, 1);
        #2 reset_in = 0;
        #1 check("async_rst", {bus.dc_req, bus.dc_rd, bus.dc_addr, count}, 0);
        sb.delete(); rq.delete();
        @(negedge clk_in) reset_in = 1;
        @(negedge clk_in);
        check("post_rst_count", count, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule
